// File: rtl/iahb_fetch_master_pkg.sv
// Shared AHB-Lite encodings and fetch FSM state type for the instruction-fetch master.
package iahb_fetch_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/iahb_fetch_master_if.sv
// AHB-Lite read-only bus bundle between the fetch master and its slave.
interface iahb_fetch_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic                  HWRITE;
    logic [3:0]            HPROT;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        output HADDR, HTRANS, HSIZE, HBURST, HWRITE, HPROT,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HSIZE, HBURST, HWRITE, HPROT,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/iahb_fetch_master.sv
// Turns each instruction-fetch request into a single-beat AHB-Lite read, returning
// the word or an error, and silently drops responses for abandoned requests.
module iahb_fetch_master
    import iahb_fetch_master_pkg::*;
#(
    parameter int         ADDR_WIDTH  = 32,
    parameter int         INSTR_WIDTH = 32,
    parameter logic [3:0] FETCH_HPROT = 4'b0010
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rstn,
    input  logic                   IAHB_access,
    input  logic [ADDR_WIDTH-1:0]  IAHB_addr,
    output logic [INSTR_WIDTH-1:0] IAHB_read_data,
    output logic                   IAHB_read_data_valid,
    output logic                   IAHB_read_error,
    iahb_fetch_master_if.master    ahb
);

    fetch_state_e          r_state,    w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_req_addr, w_req_addr_nxt;
    logic [ADDR_WIDTH-1:0] r_haddr,    w_haddr_nxt;
    logic [1:0]            r_htrans,   w_htrans_nxt;
    logic                  r_stale,    w_stale_nxt;
    logic                  w_mismatch;
    logic                  w_respond;

    // The fetch side has moved on if it dropped the request or changed the address.
    assign w_mismatch = !IAHB_access || (IAHB_addr != r_req_addr);

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_req_addr_nxt = r_req_addr;
        w_haddr_nxt    = r_haddr;
        w_htrans_nxt   = r_htrans;
        w_stale_nxt    = r_stale;
        w_respond      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_stale_nxt = 1'b0;
                if (IAHB_access) begin
                    w_req_addr_nxt = IAHB_addr;
                    w_haddr_nxt    = {IAHB_addr[ADDR_WIDTH-1:2], 2'b00};
                    w_htrans_nxt   = HTRANS_NONSEQ;
                    w_state_nxt    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                w_stale_nxt = r_stale | w_mismatch;
                if (ahb.HREADY) begin
                    w_htrans_nxt = HTRANS_IDLE;
                    w_state_nxt  = ST_DATA;
                end
            end
            ST_DATA: begin
                w_stale_nxt = r_stale | w_mismatch;
                if (ahb.HREADY) begin
                    // Same-cycle compare also suppresses the final response.
                    w_respond   = !r_stale && !w_mismatch;
                    w_stale_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_htrans_nxt = HTRANS_IDLE;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: reset is asynchronous so an in-flight transfer is abandoned at once.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_state    <= ST_IDLE;
            r_req_addr <= '0;
            r_haddr    <= '0;
            r_htrans   <= HTRANS_IDLE;
            r_stale    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_haddr    <= w_haddr_nxt;
            r_htrans   <= w_htrans_nxt;
            r_stale    <= w_stale_nxt;
        end
    end

    assign ahb.HADDR  = r_haddr;
    assign ahb.HTRANS = r_htrans;
    assign ahb.HSIZE  = HSIZE_WORD;
    assign ahb.HBURST = HBURST_SINGLE;
    assign ahb.HWRITE = 1'b0;
    assign ahb.HPROT  = FETCH_HPROT;

    assign IAHB_read_data_valid = w_respond;
    assign IAHB_read_error      = w_respond && (ahb.HRESP == HRESP_ERROR);
    assign IAHB_read_data       = (w_respond && (ahb.HRESP == HRESP_OKAY)) ? ahb.HRDATA : '0;

endmodule

// File: tb/tb_iahb_fetch_master.sv
// Self-checking bench: table of single fetches plus hand sequences for redirect,
// access drop and reset mid-transfer; responses are checked against a scoreboard.
module tb_iahb_fetch_master;
    import iahb_fetch_master_pkg::*;

    localparam int AW = 32;
    localparam int IW = 32;

    logic          cpu_clk = 1'b0;
    logic          cpu_rstn;
    logic          IAHB_access;
    logic [AW-1:0] IAHB_addr;
    logic [IW-1:0] IAHB_read_data;
    logic          IAHB_read_data_valid;
    logic          IAHB_read_error;

    iahb_fetch_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(IW)) ahb ();

    iahb_fetch_master #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .FETCH_HPROT(4'b0010)
    ) u_dut (
        .cpu_clk             (cpu_clk),
        .cpu_rstn            (cpu_rstn),
        .IAHB_access         (IAHB_access),
        .IAHB_addr           (IAHB_addr),
        .IAHB_read_data      (IAHB_read_data),
        .IAHB_read_data_valid(IAHB_read_data_valid),
        .IAHB_read_error     (IAHB_read_error),
        .ahb                 (ahb)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        resp;
        int          aw;
        int          dw;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    resp_t sb[$];
    vec_t  vecs[6];
    int    checks     = 0;
    int    failures   = 0;
    int    n_pushed   = 0;
    int    n_seen     = 0;
    bit    mon_done   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: every valid/error pulse must match the oldest expected entry.
    initial begin
        resp_t e;
        while (!mon_done) begin
            @(negedge cpu_clk);
            #2;
            if (cpu_rstn && (IAHB_read_data_valid || IAHB_read_error)) begin
                n_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_response", {62'd0, IAHB_read_data_valid, IAHB_read_error}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_valid", IAHB_read_data_valid, 1'b1);
                    check("resp_error", IAHB_read_error, e.err);
                    check("resp_data", IAHB_read_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Starts in an IDLE cycle; ends at the start of the IDLE cycle after completion.
    task automatic do_fetch(input vec_t v);
        logic [31:0] exp_haddr;
        exp_haddr     = {v.addr[31:2], 2'b00};
        IAHB_access   = 1'b1;
        IAHB_addr     = v.addr;
        ahb.HREADY    = 1'b1;
        ahb.HRESP     = 1'b0;
        ahb.HRDATA    = v.rdata;
        #1 check("t0_htrans_idle", ahb.HTRANS, HTRANS_IDLE);
        for (int i = 0; i <= v.aw; i++) begin
            @(negedge cpu_clk);
            ahb.HREADY = (i == v.aw);
            #1;
            check("addr_htrans", ahb.HTRANS, HTRANS_NONSEQ);
            check("addr_haddr", ahb.HADDR, exp_haddr);
            check("addr_no_valid", IAHB_read_data_valid, 1'b0);
            check("addr_data_zero", IAHB_read_data, 32'd0);
        end
        for (int i = 0; i <= v.dw; i++) begin
            @(negedge cpu_clk);
            ahb.HREADY = (i == v.dw);
            ahb.HRESP  = v.resp && (i >= v.dw - 1);
            if (i == v.dw) begin
                sb.push_back('{v.exp_data, v.exp_err});
                n_pushed++;
            end
            #1;
            check("data_htrans_idle", ahb.HTRANS, HTRANS_IDLE);
            check("data_valid_timing", IAHB_read_data_valid, (i == v.dw));
        end
        @(negedge cpu_clk);
        IAHB_access = 1'b0;
        ahb.HREADY  = 1'b1;
        ahb.HRESP   = 1'b0;
        #1;
        check("post_htrans_idle", ahb.HTRANS, HTRANS_IDLE);
        check("post_no_valid", IAHB_read_data_valid, 1'b0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_1000, 32'h0000_0013, 1'b0, 0, 0, 32'h0000_0013, 1'b0};
        vecs[1] = '{32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 2, 3, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{32'h0000_2000, 32'hBAD0_BAD0, 1'b1, 0, 1, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h0000_2004, 32'h00A0_0093, 1'b0, 0, 0, 32'h00A0_0093, 1'b0};
        vecs[4] = '{32'h0000_2007, 32'h1234_5678, 1'b0, 1, 0, 32'h1234_5678, 1'b0};
        vecs[5] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1, 2, 2, 32'h0000_0000, 1'b1};

        cpu_rstn    = 1'b0;
        IAHB_access = 1'b0;
        IAHB_addr   = '0;
        ahb.HREADY  = 1'b1;
        ahb.HRESP   = 1'b0;
        ahb.HRDATA  = 32'hA5A5_A5A5;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        check("rst_htrans", ahb.HTRANS, HTRANS_IDLE);
        check("rst_haddr", ahb.HADDR, 32'd0);
        check("rst_valid", IAHB_read_data_valid, 1'b0);
        check("rst_error", IAHB_read_error, 1'b0);
        check("rst_data", IAHB_read_data, 32'd0);
        check("hsize", ahb.HSIZE, 3'b010);
        check("hburst", ahb.HBURST, 3'b000);
        check("hwrite", ahb.HWRITE, 1'b0);
        check("hprot", ahb.HPROT, 4'b0010);
        cpu_rstn = 1'b1;
        @(negedge cpu_clk);

        for (int k = 0; k < 6; k++) do_fetch(vecs[k]);

        // Redirect in the final DATA cycle: response for 0x1000 dropped, 0x3000 fetched.
        IAHB_access = 1'b1;
        IAHB_addr   = 32'h0000_1000;
        ahb.HRDATA  = 32'h1111_1111;
        @(negedge cpu_clk);
        #1 check("redir_haddr", ahb.HADDR, 32'h0000_1000);
        @(negedge cpu_clk);
        IAHB_addr = 32'h0000_3000;
        #1 check("redir_suppressed", IAHB_read_data_valid, 1'b0);
        @(negedge cpu_clk);
        do_fetch('{32'h0000_3000, 32'h3333_3333, 1'b0, 0, 0, 32'h3333_3333, 1'b0});

        // Stale is sticky: a one-cycle address glitch in ADDR still suppresses.
        IAHB_access = 1'b1;
        IAHB_addr   = 32'h0000_4000;
        @(negedge cpu_clk);
        IAHB_addr = 32'h0000_4004;
        @(negedge cpu_clk);
        IAHB_addr = 32'h0000_4000;
        #1 check("sticky_suppressed", IAHB_read_data_valid, 1'b0);
        @(negedge cpu_clk);
        do_fetch('{32'h0000_4000, 32'h4444_4444, 1'b0, 0, 0, 32'h4444_4444, 1'b0});

        // Access dropped during a stalled address phase: transfer completes, no response.
        IAHB_access = 1'b1;
        IAHB_addr   = 32'h0000_5000;
        @(negedge cpu_clk);
        ahb.HREADY  = 1'b0;
        IAHB_access = 1'b0;
        #1 check("drop_htrans_held", ahb.HTRANS, HTRANS_NONSEQ);
        @(negedge cpu_clk);
        ahb.HREADY = 1'b1;
        #1 check("drop_haddr_held", ahb.HADDR, 32'h0000_5000);
        @(negedge cpu_clk);
        #1 check("drop_no_valid", IAHB_read_data_valid, 1'b0);
        @(negedge cpu_clk);
        #1 check("drop_idle", ahb.HTRANS, HTRANS_IDLE);
        @(negedge cpu_clk);
        #1 check("drop_no_reissue", ahb.HTRANS, HTRANS_IDLE);

        // Reset asserted mid data phase with HREADY rising: nothing must come out.
        IAHB_access = 1'b1;
        IAHB_addr   = 32'h0000_6000;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        ahb.HREADY = 1'b0;
        #3;
        cpu_rstn   = 1'b0;
        ahb.HREADY = 1'b1;
        #1;
        check("midrst_htrans", ahb.HTRANS, HTRANS_IDLE);
        check("midrst_valid", IAHB_read_data_valid, 1'b0);
        check("midrst_haddr", ahb.HADDR, 32'd0);
        IAHB_access = 1'b0;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        do_fetch('{32'h0000_0000, 32'h0000_0297, 1'b0, 0, 0, 32'h0000_0297, 1'b0});

        @(negedge cpu_clk);
        @(negedge cpu_clk);
        check("sb_drained", sb.size(), 0);
        check("response_count", n_seen, n_pushed);
        mon_done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
